// File: rtl/slow_clk_pkg.sv
// ---------------------------------------------------------------------------
// slow_clk_pkg
//
// Shared types and helpers for the slow_clk generator slice.
//
// Contents:
//   slow_clk_state_t  generator FSM state encoding
//   MIN_PERIOD        shortest period that still has a high and a low cycle
//   CFG_MAX_BITS      width used by cfg_is_legal(); configs are zero-extended
//                     to this width, so it must be >= the generator's N_BITS
//   cfg_is_legal()    period/high legality check shared by RTL and users
// ---------------------------------------------------------------------------
package slow_clk_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        LOW   = 2'd2,
        DRAIN = 2'd3
    } slow_clk_state_t;

    localparam int unsigned MIN_PERIOD   = 2;
    localparam int unsigned CFG_MAX_BITS = 64;

    // A period needs at least one high and one low cycle, so the high time
    // must land strictly between zero and the period.
    function automatic logic cfg_is_legal(
        input logic [CFG_MAX_BITS-1:0] period,
        input logic [CFG_MAX_BITS-1:0] high
    );
        logic ok;
        ok = (period >= CFG_MAX_BITS'(MIN_PERIOD))
          && (high != '0)
          && (high < period);
        return ok;
    endfunction

endpackage

// File: rtl/slow_clk_generator_if.sv
// ---------------------------------------------------------------------------
// slow_clk_generator_if
//
// Configuration load handshake for slow_clk_generator.
//
// Signals:
//   period_cycles  requested period in fast_clk cycles, sampled on load
//   high_cycles    requested high time in fast_clk cycles, sampled on load
//   load           single-cycle load request
//   load_ack       one-cycle pulse when the requested config becomes active
//   config_error   one-cycle pulse when a load is rejected as illegal
//
// Modports:
//   master  configuration source (drives the request, sees ack/error)
//   slave   the generator
// ---------------------------------------------------------------------------
interface slow_clk_generator_if #(
    parameter int N_BITS = 32
);

    logic [N_BITS-1:0] period_cycles;
    logic [N_BITS-1:0] high_cycles;
    logic              load;
    logic              load_ack;
    logic              config_error;

    modport master (
        output period_cycles,
        output high_cycles,
        output load,
        input  load_ack,
        input  config_error
    );

    modport slave (
        input  period_cycles,
        input  high_cycles,
        input  load,
        output load_ack,
        output config_error
    );

endinterface

// File: rtl/slow_clk_cfg_shadow.sv
// ---------------------------------------------------------------------------
// slow_clk_cfg_shadow
//
// Active/pending configuration registers for slow_clk_generator.
//
// A legal load either takes effect on the next cycle (cfg_immediate, i.e. the
// generator is idle or is entering idle this cycle) or is parked in the
// pending register until the generator signals a period boundary
// (apply_pending). A later legal load overwrites an unapplied pending one, so
// only one load_ack is produced per applied config. Illegal loads touch
// nothing and produce a config_error pulse on the next cycle.
//
// Ports:
//   fast_clk       clock
//   reset          asynchronous active-low reset
//   load           load request
//   period_cycles  requested period, sampled with load
//   high_cycles    requested high time, sampled with load
//   cfg_immediate  a load this cycle goes straight to the active registers
//   apply_pending  period boundary: promote pending config to active
//   active_period  period currently used by the generator
//   active_high    high time currently used by the generator
//   load_ack       pulse in the first cycle a newly loaded config is active
//   config_error   pulse one cycle after an illegal load
// ---------------------------------------------------------------------------
module slow_clk_cfg_shadow
    import slow_clk_pkg::*;
#(
    parameter int N_BITS         = 32,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int DEFAULT_HIGH   = 500
) (
    input  logic              fast_clk,
    input  logic              reset,
    input  logic              load,
    input  logic [N_BITS-1:0] period_cycles,
    input  logic [N_BITS-1:0] high_cycles,
    input  logic              cfg_immediate,
    input  logic              apply_pending,
    output logic [N_BITS-1:0] active_period,
    output logic [N_BITS-1:0] active_high,
    output logic              load_ack,
    output logic              config_error
);

    logic [N_BITS-1:0] pend_period;
    logic [N_BITS-1:0] pend_high;
    logic              pend_valid;
    logic              req_legal;
    logic              load_ok;
    logic              load_bad;

    assign req_legal = cfg_is_legal(CFG_MAX_BITS'(period_cycles),
                                    CFG_MAX_BITS'(high_cycles));
    assign load_ok   = load && req_legal;
    assign load_bad  = load && !req_legal;

    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            active_period <= N_BITS'(DEFAULT_PERIOD);
            active_high   <= N_BITS'(DEFAULT_HIGH);
            pend_period   <= '0;
            pend_high     <= '0;
            pend_valid    <= 1'b0;
            load_ack      <= 1'b0;
            config_error  <= 1'b0;
        end else begin
            load_ack     <= 1'b0;
            config_error <= load_bad;

            if (load_ok && cfg_immediate) begin
                // Idle (or going idle): nothing is mid-phase, apply now. Any
                // stale pending config is superseded by this newer request.
                active_period <= period_cycles;
                active_high   <= high_cycles;
                pend_valid    <= 1'b0;
                load_ack      <= 1'b1;
            end else begin
                if (apply_pending && pend_valid) begin
                    active_period <= pend_period;
                    active_high   <= pend_high;
                    pend_valid    <= 1'b0;
                    load_ack      <= 1'b1;
                end
                // A load coincident with the boundary is parked, not applied;
                // this later assignment wins over the clear above.
                if (load_ok) begin
                    pend_period <= period_cycles;
                    pend_high   <= high_cycles;
                    pend_valid  <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/slow_clk_generator.sv
// ---------------------------------------------------------------------------
// slow_clk_generator
//
// Programmable divider producing slow_clk from fast_clk. The period and high
// time come from a shadowed configuration that only changes at a period
// boundary or while idle, so a phase is never truncated. All outputs are
// registered, so slow_clk and the strobes are glitch-free.
//
// state | meaning
// ------+------------------------------------------------------------------
// IDLE  | stopped, slow_clk low, count held at 0
// HIGH  | slow_clk high, count < high
// LOW   | slow_clk low, high <= count < period, enable still requested
// DRAIN | as LOW but enable withdrawn; stops at the period boundary
//
// Ports:
//   fast_clk     sole clock
//   reset        asynchronous active-low reset, drops slow_clk immediately
//   enable       level-sensitive run request
//   cfg          configuration load handshake (slave side)
//   slow_clk     generated clock
//   rise_strobe  one fast_clk cycle pulse, first cycle slow_clk is high
//   fall_strobe  one fast_clk cycle pulse, first cycle slow_clk is low
//   running      high while not IDLE
// ---------------------------------------------------------------------------
module slow_clk_generator
    import slow_clk_pkg::*;
#(
    parameter int N_BITS         = 32,
    parameter int DEFAULT_PERIOD = 1000,
    parameter int DEFAULT_HIGH   = 500
) (
    input  logic                 fast_clk,
    input  logic                 reset,
    input  logic                 enable,
    slow_clk_generator_if.slave  cfg,
    output logic                 slow_clk,
    output logic                 rise_strobe,
    output logic                 fall_strobe,
    output logic                 running
);

    slow_clk_state_t   state;
    slow_clk_state_t   next_state;
    logic [N_BITS-1:0] count;
    logic [N_BITS-1:0] next_count;

    logic [N_BITS-1:0] active_period;
    logic [N_BITS-1:0] active_high;
    logic              high_done;
    logic              period_done;
    logic              cfg_immediate;

    logic              slow_clk_d;
    logic              rise_strobe_d;
    logic              fall_strobe_d;
    logic              running_d;

    slow_clk_cfg_shadow #(
        .N_BITS         (N_BITS),
        .DEFAULT_PERIOD (DEFAULT_PERIOD),
        .DEFAULT_HIGH   (DEFAULT_HIGH)
    ) u_cfg_shadow (
        .fast_clk      (fast_clk),
        .reset         (reset),
        .load          (cfg.load),
        .period_cycles (cfg.period_cycles),
        .high_cycles   (cfg.high_cycles),
        .cfg_immediate (cfg_immediate),
        .apply_pending (period_done),
        .active_period (active_period),
        .active_high   (active_high),
        .load_ack      (cfg.load_ack),
        .config_error  (cfg.config_error)
    );

    // Legal configs guarantee high >= 1 and period >= 2, so the minus-one
    // terms cannot wrap and count never exceeds period - 1.
    assign high_done   = (state == HIGH) && (count == active_high - N_BITS'(1));
    assign period_done = ((state == LOW) || (state == DRAIN))
                      && (count == active_period - N_BITS'(1));

    // Loads are applied directly while nothing is mid-period: already idle,
    // or stopping at this boundary.
    assign cfg_immediate = (state == IDLE) || (next_state == IDLE);

    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= next_state;
            count <= next_count;
        end
    end

    always_comb begin
        next_state = state;
        next_count = count;

        case (state)
            IDLE: begin
                next_count = '0;
                if (enable) begin
                    next_state = HIGH;
                end
            end

            HIGH: begin
                next_count = count + N_BITS'(1);
                if (high_done) begin
                    next_state = enable ? LOW : DRAIN;
                end
            end

            LOW, DRAIN: begin
                if (period_done) begin
                    next_count = '0;
                    next_state = enable ? HIGH : IDLE;
                end else begin
                    // enable may come and go during the low phase; only its
                    // value at the boundary decides whether we stop.
                    next_count = count + N_BITS'(1);
                    next_state = enable ? LOW : DRAIN;
                end
            end

            default: begin
                next_count = '0;
                next_state = IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state and registered, so they
    // switch on the same edge as the state they describe.
    always_comb begin
        slow_clk_d    = (next_state == HIGH);
        rise_strobe_d = (next_state == HIGH) && (state != HIGH);
        fall_strobe_d = (state == HIGH)
                     && ((next_state == LOW) || (next_state == DRAIN));
        running_d     = (next_state != IDLE);
    end

    always_ff @(posedge fast_clk or negedge reset) begin
        if (!reset) begin
            slow_clk    <= 1'b0;
            rise_strobe <= 1'b0;
            fall_strobe <= 1'b0;
            running     <= 1'b0;
        end else begin
            slow_clk    <= slow_clk_d;
            rise_strobe <= rise_strobe_d;
            fall_strobe <= fall_strobe_d;
            running     <= running_d;
        end
    end

endmodule

// File: tb/tb_slow_clk_generator.sv
// ---------------------------------------------------------------------------
// tb_slow_clk_generator
//
// Directed stimulus pushes the hand-computed cycle of every expected event
// (rise/fall strobe, load_ack, config_error) into a time-ordered scoreboard.
// A negedge monitor pops and compares whenever an event is due or seen.
// Level spot checks cover reset, running, and the async reset drop.
// ---------------------------------------------------------------------------
module tb_slow_clk_generator;

    localparam int N_BITS = 32;

    localparam logic [3:0] EV_RISE = 4'b0001;
    localparam logic [3:0] EV_FALL = 4'b0010;
    localparam logic [3:0] EV_ACK  = 4'b0100;
    localparam logic [3:0] EV_ERR  = 4'b1000;

    typedef struct {
        int         cyc;
        logic [3:0] ev;
    } exp_t;

    logic fast_clk;
    logic reset;
    logic enable;
    logic slow_clk;
    logic rise_strobe;
    logic fall_strobe;
    logic running;

    slow_clk_generator_if #(.N_BITS(N_BITS)) cfg_if ();

    slow_clk_generator #(
        .N_BITS         (N_BITS),
        .DEFAULT_PERIOD (1000),
        .DEFAULT_HIGH   (500)
    ) u_dut (
        .fast_clk    (fast_clk),
        .reset       (reset),
        .enable      (enable),
        .cfg         (cfg_if),
        .slow_clk    (slow_clk),
        .rise_strobe (rise_strobe),
        .fall_strobe (fall_strobe),
        .running     (running)
    );

    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb_q[$];

    initial fast_clk = 1'b0;
    always #5 fast_clk = ~fast_clk;

    always @(posedge fast_clk) cyc <= cyc + 1;

    // Insert keeping the queue sorted by cycle; coincident events merge.
    function automatic void exp_add(input int c, input logic [3:0] ev);
        int   i;
        exp_t e;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].cyc == c) begin
                sb_q[i].ev = sb_q[i].ev | ev;
                return;
            end
            if (sb_q[i].cyc > c) break;
            i++;
        end
        e.cyc = c;
        e.ev  = ev;
        sb_q.insert(i, e);
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge fast_clk);
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic do_load(input int p, input int h, input bit legal);
        cfg_if.period_cycles = N_BITS'(p);
        cfg_if.high_cycles   = N_BITS'(h);
        cfg_if.load          = 1'b1;
        if (!legal) exp_add(cyc + 1, EV_ERR);
        tick();
        cfg_if.load = 1'b0;
    endtask

    // Monitor: compares observed strobes/pulses against the scoreboard.
    always @(negedge fast_clk) begin : monitor
        logic [3:0] ev_now;
        exp_t       e;
        ev_now = {cfg_if.config_error, cfg_if.load_ack, fall_strobe, rise_strobe};
        while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL missed_event: cycle %0d expected %b, not seen", e.cyc, e.ev);
        end
        if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
            e = sb_q.pop_front();
            n_checks++;
            if (ev_now !== e.ev) begin
                n_errors++;
                $display("FAIL event_mismatch: cycle %0d got %b, expected %b",
                         cyc, ev_now, e.ev);
            end
        end else if (ev_now !== 4'b0000) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_event: cycle %0d got %b, expected 0000",
                     cyc, ev_now);
        end
    end

    int t0, b, p, q, s, t1, u;

    initial begin
        reset                = 1'b1;
        enable               = 1'b0;
        cfg_if.load          = 1'b0;
        cfg_if.period_cycles = '0;
        cfg_if.high_cycles   = '0;
        #2 reset = 1'b0;

        repeat (3) tick();
        check("reset_outputs",
              {26'd0, slow_clk, rise_strobe, fall_strobe, cfg_if.load_ack,
               cfg_if.config_error, running}, 32'd0);
        reset = 1'b1;

        // Illegal load while idle
        wait_until(6);
        do_load(10, 0, 1'b0);
        wait_until(9);
        check("idle_not_running", {31'd0, running}, 32'd0);

        // Defaults: 500 high / 500 low
        wait_until(10);
        enable = 1'b1;
        t0 = cyc;
        exp_add(t0 + 1,   EV_RISE);
        exp_add(t0 + 501, EV_FALL);
        wait_until(t0 + 2);
        check("running_after_start", {31'd0, running}, 32'd1);

        // Runtime load mid-high: current period untouched, applied at wrap
        wait_until(t0 + 100);
        do_load(10, 3, 1'b1);
        wait_until(t0 + 300);
        check("default_high_level", {31'd0, slow_clk}, 32'd1);
        wait_until(t0 + 1000);
        check("default_low_last", {31'd0, slow_clk}, 32'd0);

        b = t0 + 1001;
        exp_add(b, EV_RISE | EV_ACK);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) exp_add(b + 10 * k, EV_RISE);
            exp_add(b + 10 * k + 3, EV_FALL);
        end

        // Illegal loads while running: waveform unchanged
        wait_until(b + 21);
        do_load(10, 0, 1'b0);
        wait_until(b + 25);
        do_load(10, 10, 1'b0);
        wait_until(b + 33);
        do_load(1, 1, 1'b0);

        // Stop at count 1: high phase completes, idle after count 9
        wait_until(b + 41);
        enable = 1'b0;
        wait_until(b + 45);
        check("drain_running", {31'd0, running}, 32'd1);
        wait_until(b + 49);
        check("drain_last_cycle", {31'd0, running}, 32'd1);
        wait_until(b + 50);
        check("stopped_running", {31'd0, running}, 32'd0);
        check("stopped_slow_clk", {31'd0, slow_clk}, 32'd0);

        // Restart, drop at count 1, re-enable at count 5: no gap at wrap
        wait_until(b + 55);
        enable = 1'b1;
        p = b + 56;
        exp_add(p,      EV_RISE);
        exp_add(p + 3,  EV_FALL);
        exp_add(p + 10, EV_RISE);
        exp_add(p + 13, EV_FALL);
        wait_until(p + 1);
        enable = 1'b0;
        wait_until(p + 5);
        enable = 1'b1;
        wait_until(p + 9);
        check("reenabled_running", {31'd0, running}, 32'd1);

        // Overwrite: (8,4) then (6,2) in one period, single ack
        q = p + 10;
        wait_until(q + 1);
        do_load(8, 4, 1'b1);
        wait_until(q + 4);
        do_load(6, 2, 1'b1);
        exp_add(q + 10, EV_RISE | EV_ACK);
        exp_add(q + 12, EV_FALL);
        exp_add(q + 16, EV_RISE);
        exp_add(q + 18, EV_FALL);

        // Load coincident with wrap (count 5 of 6): applied one wrap later
        wait_until(q + 15);
        do_load(10, 3, 1'b1);
        exp_add(q + 22, EV_RISE | EV_ACK);
        exp_add(q + 25, EV_FALL);
        exp_add(q + 32, EV_RISE);

        // Async reset at count 2 of the high phase
        s = q + 32;
        wait_until(s + 2);
        check("high_before_reset", {31'd0, slow_clk}, 32'd1);
        enable = 1'b0;
        #1 reset = 1'b0;
        #1;
        check("async_reset_slow_clk", {31'd0, slow_clk}, 32'd0);
        check("async_reset_running", {31'd0, running}, 32'd0);
        repeat (3) tick();
        reset = 1'b1;
        repeat (3) tick();

        // Defaults restored after reset
        enable = 1'b1;
        t1 = cyc;
        exp_add(t1 + 1,    EV_RISE);
        exp_add(t1 + 501,  EV_FALL);
        exp_add(t1 + 1001, EV_RISE);
        exp_add(t1 + 1501, EV_FALL);
        wait_until(t1 + 1100);
        enable = 1'b0;
        wait_until(t1 + 2000);
        check("default_last_cycle", {31'd0, running}, 32'd1);
        wait_until(t1 + 2001);
        check("default_stopped", {31'd0, running}, 32'd0);

        // Load while idle: ack next cycle, new config used on start
        wait_until(t1 + 2005);
        u = cyc;
        exp_add(u + 1, EV_ACK);
        do_load(4, 1, 1'b1);
        wait_until(u + 3);
        enable = 1'b1;
        exp_add(u + 4, EV_RISE);
        exp_add(u + 5, EV_FALL);
        wait_until(u + 6);
        enable = 1'b0;
        wait_until(u + 7);
        check("short_last_cycle", {31'd0, running}, 32'd1);
        wait_until(u + 8);
        check("short_stopped", {31'd0, running}, 32'd0);

        repeat (5) tick();
        check("scoreboard_drained", sb_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
